if_id_skid: RTL and testbench

Parametrised IF/ID pipeline register for the CPU front end, placed between instruction fetch and decode. It replaces the fixed, always-advancing stage register with a valid/ready handshake. A two-entry skid buffer lets IF keep a registered ready while ID back-pressures. The block also provides a flush for branch redirect, optional instruction byte reversal for little-endian memory, and a saturating stall counter.

---
 rtl/if_id_skid.sv | 94 +++++++++
 tb/tb_if_id_skid.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// if_id_skid: IF/ID pipeline register with a valid/ready handshake, a two-entry skid buffer, flush, byte swap and a stall counter
module if_id_skid #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int SWAP_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic [INST_W-1:0] if_inst_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  state_t state, state_n;
  logic acc, con, ld_main, ld_skid, mv_skid;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst, in_x;
  function automatic logic [INST_W-1:0] xf(input logic [INST_W-1:0] d);
    xf = d;
    if (SWAP_EN != 0)
      for (int k = 0; k < INST_W / 8; k++) xf[8*k +: 8] = d[INST_W-8-8*k +: 8];
  endfunction
  assign acc        = if_valid_i & if_ready_o;
  assign con        = id_valid_o & id_ready_i;
  assign id_valid_o = state != EMPTY;
  assign in_x       = xf(if_inst_i);
  // next state and load steering; the skid entry is always the younger instruction
  always_comb begin
    state_n = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state)
      EMPTY: begin
        ld_main = acc;
        state_n = acc ? FULL : EMPTY;
      end
      FULL: begin
        ld_main = acc & con;
        ld_skid = acc & ~con;
        state_n = (acc & ~con) ? SKID : (con & ~acc) ? EMPTY : FULL;
      end
      SKID: begin
        mv_skid = con;
        state_n = con ? FULL : SKID;
      end
      default: state_n = EMPTY;
    endcase
  end
  // state register; ready is registered as "skid entry will be empty"
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state      <= EMPTY;
      if_ready_o <= 1'b1;
    end else begin
      state      <= state_n;
      if_ready_o <= state_n != SKID;
    end
  end
  // main and skid data entries
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      id_pc_o   <= '0;
      id_inst_o <= '0;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else begin
      if (ld_main) begin
        id_pc_o   <= if_pc_i;
        id_inst_o <= in_x;
      end else if (mv_skid) begin
        id_pc_o   <= skid_pc;
        id_inst_o <= skid_inst;
      end
      if (ld_skid) begin
        skid_pc   <= if_pc_i;
        skid_inst <= in_x;
      end
    end
  end
  // saturating stall counter, deliberately untouched by flush
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_o <= '0;
    else if (id_valid_o && !id_ready_i && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
  end
endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: randomized and directed checks of if_id_skid against a queue model
module tb_if_id_skid;
  logic clk = 0, rst = 1, flush = 0, iv = 0, ir = 0;
  logic [31:0] pc = '0;
  logic [63:0] inst = '0;
  logic r0, r1, r2, r3, v0, v1, v2, v3;
  logic [31:0] p0, p1, p2, p3, i0, i1;
  logic [63:0] i2, i3;
  logic [15:0] c0, c2, c3;
  logic [3:0] c1;
  int tests = 0, fails = 0;
  bit go = 0;
  logic [31:0] q_pc[$];
  logic [63:0] q_in[$];
  int m_cnt = 0, m_cnt4 = 0;
  bit mz = 1;
  always #5 clk = ~clk;
  if_id_skid d0 (.clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(iv), .if_ready_o(r0), .if_pc_i(pc),
    .if_inst_i(inst[31:0]), .id_valid_o(v0), .id_ready_i(ir), .id_pc_o(p0), .id_inst_o(i0), .stall_cnt_o(c0));
  if_id_skid #(.CNT_W(4)) d1 (.clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(iv), .if_ready_o(r1), .if_pc_i(pc),
    .if_inst_i(inst[31:0]), .id_valid_o(v1), .id_ready_i(ir), .id_pc_o(p1), .id_inst_o(i1), .stall_cnt_o(c1));
  if_id_skid #(.INST_W(64), .SWAP_EN(0)) d2 (.clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(iv), .if_ready_o(r2),
    .if_pc_i(pc), .if_inst_i(inst), .id_valid_o(v2), .id_ready_i(ir), .id_pc_o(p2), .id_inst_o(i2), .stall_cnt_o(c2));
  if_id_skid #(.INST_W(64), .SWAP_EN(1)) d3 (.clk(clk), .rst(rst), .flush_i(flush), .if_valid_i(iv), .if_ready_o(r3),
    .if_pc_i(pc), .if_inst_i(inst), .id_valid_o(v3), .id_ready_i(ir), .id_pc_o(p3), .id_inst_o(i3), .stall_cnt_o(c3));
  function automatic logic [31:0] sw32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction
  function automatic logic [63:0] sw64(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 8; k++) y[8*k +: 8] = x[8*(7-k) +: 8];
    return y;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  // reference model: a FIFO of at most two instructions
  always @(posedge clk) begin
    bit acc, con;
    acc = iv && q_pc.size() < 2;
    con = q_pc.size() > 0 && ir;
    if (rst) begin
      q_pc.delete(); q_in.delete(); m_cnt = 0; m_cnt4 = 0; mz = 1;
    end else begin
      if (q_pc.size() > 0 && !ir) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (flush) begin
        q_pc.delete(); q_in.delete(); mz = 1;
      end else begin
        if (con) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
        if (acc) begin q_pc.push_back(pc); q_in.push_back(inst); mz = 0; end
      end
    end
  end
  // compare every DUT against the model just after each edge
  always @(posedge clk) begin
    #1;
    if (go) begin
      chk("valid0", v0, q_pc.size() > 0);
      chk("valid1", v1, q_pc.size() > 0);
      chk("valid2", v2, q_pc.size() > 0);
      chk("valid3", v3, q_pc.size() > 0);
      chk("ready0", r0, q_pc.size() < 2);
      chk("ready1", r1, q_pc.size() < 2);
      chk("ready2", r2, q_pc.size() < 2);
      chk("ready3", r3, q_pc.size() < 2);
      chk("cnt0", c0, m_cnt);
      chk("cnt1", c1, m_cnt4);
      if (q_pc.size() > 0) begin
        chk("pc0", p0, q_pc[0]);
        chk("pc1", p1, q_pc[0]);
        chk("pc2", p2, q_pc[0]);
        chk("pc3", p3, q_pc[0]);
        chk("inst0", i0, sw32(q_in[0][31:0]));
        chk("inst1", i1, sw32(q_in[0][31:0]));
        chk("inst2", i2, q_in[0]);
        chk("inst3", i3, sw64(q_in[0]));
      end else if (mz) begin
        chk("zpc0", p0, 0);
        chk("zinst0", i0, 0);
        chk("zinst3", i3, 0);
      end
    end
  end
  initial begin
    @(posedge clk);
    @(posedge clk);
    go = 1;
    @(negedge clk);
    chk("rst_valid", v0, 0); chk("rst_pc", p0, 0); chk("rst_inst", i0, 0);
    chk("rst_ready", r0, 1); chk("rst_cnt", c0, 0);
    rst = 0; iv = 1; pc = 32'h1000; inst = 64'h13000000; ir = 1;
    @(posedge clk); @(negedge clk);
    chk("t1_valid", v0, 1); chk("t1_pc", p0, 32'h1000); chk("t1_inst", i0, 32'h00000013);
    for (int i = 0; i < 4; i++) begin
      pc = 32'(4 * i); inst = 64'($urandom);
      @(posedge clk); @(negedge clk);
      chk("t2_pc", p0, 32'(4 * i)); chk("t2_ready", r0, 1);
    end
    iv = 0;
    @(posedge clk); @(negedge clk);
    chk("t2_cnt", c0, 0); chk("t2_empty", v0, 0);
    ir = 0; iv = 1; pc = 32'h20;
    @(posedge clk); @(negedge clk);
    pc = 32'h24;
    @(posedge clk); @(negedge clk);
    iv = 0;
    chk("t3_ready", r0, 0); chk("t3_pc", p0, 32'h20); chk("t3_cnt1", c0, 1);
    @(posedge clk); @(negedge clk);
    chk("t3_hold", p0, 32'h20); chk("t3_cnt2", c0, 2);
    ir = 1;
    @(posedge clk); @(negedge clk);
    chk("t3_pc2", p0, 32'h24); chk("t3_ready2", r0, 1);
    ir = 0; iv = 1; pc = 32'h28;
    @(posedge clk); @(negedge clk);
    chk("t4_skid", r0, 0);
    flush = 1; pc = 32'h2c;
    @(posedge clk); @(negedge clk);
    flush = 0; iv = 0;
    chk("t4_valid", v0, 0); chk("t4_pc", p0, 0); chk("t4_inst", i0, 0);
    chk("t4_ready", r0, 1); chk("t4_cnt", c0, 4);
    @(posedge clk); @(negedge clk);
    chk("t4_idle", v0, 0);
    iv = 1; pc = 32'h40;
    @(posedge clk); @(negedge clk);
    iv = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t5_cnt16", c0, 24); chk("t5_sat", c1, 15); chk("t5_pc", p1, 32'h40);
    ir = 1; iv = 1; pc = 32'h50; inst = 64'h0123456789ABCDEF;
    @(posedge clk); @(negedge clk);
    chk("t6_raw", i2, 64'h0123456789ABCDEF); chk("t6_swap64", i3, 64'hEFCDAB8967452301);
    chk("t6_swap32", i0, 32'hEFCDAB89);
    iv = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = $urandom_range(0, 255) == 0;
      flush = $urandom_range(0, 15) == 0;
      iv = $urandom_range(0, 3) != 0;
      ir = $urandom_range(0, 2) != 0;
      pc = $urandom;
      inst = {$urandom, $urandom};
    end
    @(negedge clk);
    rst = 0; flush = 0; iv = 0; ir = 1;
    repeat (4) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
